spi_rx_deserializer: RTL and testbench

Receive-side data path of the SPI peripheral and the counterpart of the transmit shifter: samples the DQ lines on strobes supplied by the serial-clock generator and assembles 1–8-bit frames in single, dual or quad protocol. Completed frames are buffered in a small FIFO and presented to the register interface through a valid/ready port. Protocol, bit order and frame length come from the control registers and are latched per frame.

---
 rtl/spi_pkg.sv | 49 ++++
 rtl/spi_rx_fifo.sv | 58 +++++
 rtl/spi_rx_deserializer.sv | 139 +++++++++++++
 tb/tb_spi_rx_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: protocol encodings, maximum frame length, receive FSM
// states and small decode helpers used by the receive data path.
package spi_pkg;

  localparam logic [1:0] PROTO_SINGLE = 2'd0;
  localparam logic [1:0] PROTO_DUAL   = 2'd1;
  localparam logic [1:0] PROTO_QUAD   = 2'd2;

  localparam int SPI_MAX_LEN = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  // Out-of-range lengths (0, 9..15) fall back to a full byte.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len == 4'd0 || len > 4'(SPI_MAX_LEN)) begin
      return 4'(SPI_MAX_LEN);
    end
    return len;
  endfunction

  function automatic logic [2:0] proto_step(input logic [1:0] proto);
    case (proto)
      PROTO_DUAL: return 3'd2;
      PROTO_QUAD: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

  // Right-justified bits of one sample; single mode listens on dq[1] only.
  function automatic logic [3:0] lane_bits(input logic [1:0] proto, input logic [3:0] dq);
    case (proto)
      PROTO_DUAL: return {2'b00, dq[1:0]};
      PROTO_QUAD: return dq;
      default:    return {3'b000, dq[1]};
    endcase
  endfunction

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (4'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive frame FIFO: DEPTH x 8 bits, first-word-fall-through head, push is
// accepted while full only when a pop happens in the same cycle.
module spi_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [7:0]             i_push_data,
  input  logic                   i_pop,
  output logic [7:0]             o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_rd;
  logic w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_count = r_count;
  assign o_data  = o_empty ? 8'h00 : r_mem[r_rd];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_rd) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: assembles 1..8-bit single/dual/quad frames from
// strobed DQ samples and queues completed frames in a small FIFO.
import spi_pkg::*;

module spi_rx_deserializer #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_cfg_proto,
  input  logic                   i_cfg_endian,
  input  logic [3:0]             i_cfg_len,
  input  logic                   i_frame_start,
  input  logic                   i_sample,
  input  logic [3:0]             i_dq,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic [7:0]             o_rx_data,
  output logic [$clog2(DEPTH):0] o_rx_count,
  output logic                   o_overflow,
  input  logic                   i_clear_ovf,
  output logic                   o_busy
);

  rx_state_t  r_state;
  logic [1:0] r_proto;
  logic       r_endian;
  logic [3:0] r_len;
  logic [3:0] r_cnt;
  logic [7:0] r_sr;
  logic       r_ovf;

  logic [1:0] w_proto;
  logic       w_endian;
  logic [3:0] w_len;
  logic [3:0] w_cnt;
  logic [7:0] w_sr;
  logic [2:0] w_step;
  logic [3:0] w_bits;
  logic [4:0] w_sum;
  logic [3:0] w_need;
  logic       w_act;
  logic       w_done;
  logic [7:0] w_lsb_acc;
  logic [7:0] w_msb_acc;
  logic [7:0] w_msb_last;
  logic [7:0] w_next_sr;
  logic [7:0] w_frame;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_drop;

  // A frame_start in the same cycle as a sample makes that sample the first
  // bit(s) of the new frame, so configuration and state bypass the registers.
  assign w_proto  = i_frame_start ? i_cfg_proto : r_proto;
  assign w_endian = i_frame_start ? i_cfg_endian : r_endian;
  assign w_len    = i_frame_start ? eff_len(i_cfg_len) : r_len;
  assign w_cnt    = i_frame_start ? 4'd0 : r_cnt;
  assign w_sr     = i_frame_start ? 8'h00 : r_sr;

  assign w_step = proto_step(w_proto);
  assign w_bits = lane_bits(w_proto, i_dq);
  assign w_sum  = {1'b0, w_cnt} + {2'b00, w_step};
  assign w_need = w_len - w_cnt;
  assign w_act  = i_sample & (i_frame_start | (r_state == ST_SHIFT));
  assign w_done = w_act & (w_sum >= {1'b0, w_len});

  assign w_lsb_acc  = w_sr | ({4'b0000, w_bits} << w_cnt);
  assign w_msb_acc  = (w_sr << w_step) | {4'b0000, w_bits};
  // On the final MSB-first sample only the earliest (highest-lane) bits count.
  assign w_msb_last = (w_sr << w_need) | {4'b0000, w_bits >> ({1'b0, w_step} - w_need)};

  assign w_next_sr = w_endian ? w_lsb_acc : w_msb_acc;
  assign w_frame   = w_endian ? (w_lsb_acc & len_mask(w_len)) : w_msb_last;

  assign w_pop  = ~w_empty & i_rx_ready;
  assign w_drop = w_done & w_full & ~w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_proto  <= PROTO_SINGLE;
      r_endian <= 1'b0;
      r_len    <= 4'd0;
      r_cnt    <= 4'd0;
      r_sr     <= 8'h00;
    end else begin
      if (i_frame_start) begin
        r_proto  <= i_cfg_proto;
        r_endian <= i_cfg_endian;
        r_len    <= eff_len(i_cfg_len);
      end
      if (w_done) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
        r_sr    <= 8'h00;
      end else if (w_act) begin
        r_state <= ST_SHIFT;
        r_cnt   <= w_sum[3:0];
        r_sr    <= w_next_sr;
      end else if (i_frame_start) begin
        r_state <= ST_SHIFT;
        r_cnt   <= 4'd0;
        r_sr    <= 8'h00;
      end
    end
  end

  // A fresh drop wins over a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  spi_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_done),
    .i_push_data (w_frame),
    .i_pop       (i_rx_ready),
    .o_data      (o_rx_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (o_rx_count)
  );

  assign o_rx_valid = ~w_empty;
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Bench for spi_rx_deserializer: directed scenarios followed by random traffic,
// all checked against a bit-stream / queue reference model.
module tb_spi_rx_deserializer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_proto;
  logic       cfg_endian;
  logic [3:0] cfg_len;
  logic       fs;
  logic       smp;
  logic [3:0] dq;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic [2:0] rx_count;
  logic       overflow;
  logic       clear_ovf;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: frame kept as a time-ordered list of received bits.
  int         q[$];
  bit         mbits[$];
  bit         m_busy;
  bit         m_ovf;
  logic [1:0] m_proto;
  bit         m_lsb;
  int         m_len;

  spi_rx_deserializer #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_proto   (cfg_proto),
    .i_cfg_endian  (cfg_endian),
    .i_cfg_len     (cfg_len),
    .i_frame_start (fs),
    .i_sample      (smp),
    .i_dq          (dq),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_rx_data     (rx_data),
    .o_rx_count    (rx_count),
    .o_overflow    (overflow),
    .i_clear_ovf   (clear_ovf),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int  lanes[$];
    int  v;
    bit  ovf_set;
    if (rst) begin
      q.delete();
      mbits.delete();
      m_busy = 0;
      m_ovf  = 0;
      return;
    end
    ovf_set = 0;
    if (q.size() > 0 && rx_ready) void'(q.pop_front());
    if (fs) begin
      m_busy  = 1;
      m_proto = cfg_proto;
      m_lsb   = cfg_endian;
      m_len   = (cfg_len == 0 || cfg_len > 8) ? 8 : int'(cfg_len);
      mbits.delete();
    end
    if (smp && m_busy) begin
      if (m_proto == 2'd2)      lanes = '{0, 1, 2, 3};
      else if (m_proto == 2'd1) lanes = '{0, 1};
      else                      lanes = '{1};
      if (m_lsb) begin
        foreach (lanes[k]) mbits.push_back(dq[lanes[k]]);
      end else begin
        for (int k = lanes.size() - 1; k >= 0; k--) mbits.push_back(dq[lanes[k]]);
      end
      if (mbits.size() >= m_len) begin
        v = 0;
        for (int i = 0; i < m_len; i++) begin
          if (mbits[i]) v |= m_lsb ? (1 << i) : (1 << (m_len - 1 - i));
        end
        if (q.size() < DEPTH) q.push_back(v);
        else ovf_set = 1;
        m_busy = 0;
        mbits.delete();
      end
    end
    if (ovf_set) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rx_valid", 32'(rx_valid), 32'(q.size() > 0));
    chk("rx_data", 32'(rx_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("rx_count", 32'(rx_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic cyc(input logic f, input logic s, input logic [3:0] d);
    fs = f; smp = s; dq = d;
    tick();
    fs = 1'b0; smp = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] p, input logic e, input logic [3:0] l);
    cfg_proto = p; cfg_endian = e; cfg_len = l;
  endtask

  task automatic single_stream(input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, {2'b00, pat[i], 1'b0});
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; smp = 1'b0; dq = 4'h0; rx_ready = 1'b0; clear_ovf = 1'b0;
    set_cfg(2'd0, 1'b0, 4'd8);
    m_busy = 0; m_ovf = 0; m_proto = 2'd0; m_lsb = 0; m_len = 8;
    tick();
    tick();
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_count", 32'(rx_count), 32'd0);
    rst = 1'b0;
    tick();

    // Single MSB-first 0xA5
    set_cfg(2'd0, 1'b0, 4'd8);
    cyc(1'b1, 1'b0, 4'h0);
    single_stream(8'hA5);
    chk("single_msb_a5", 32'(rx_data), 32'hA5);
    chk("single_msb_valid", 32'(rx_valid), 32'd1);
    pop_one();

    // Single LSB-first
    set_cfg(2'd0, 1'b1, 4'd8);
    cyc(1'b1, 1'b0, 4'h0);
    single_stream(8'hA5);
    chk("single_lsb_a5", 32'(rx_data), 32'hA5);
    pop_one();
    cyc(1'b1, 1'b0, 4'h0);
    single_stream(8'hC0);
    chk("single_lsb_03", 32'(rx_data), 32'h03);
    pop_one();

    // Quad MSB-first, full byte and truncated 6-bit frame
    set_cfg(2'd2, 1'b0, 4'd8);
    cyc(1'b1, 1'b1, 4'h3);
    cyc(1'b0, 1'b1, 4'hC);
    chk("quad_3c", 32'(rx_data), 32'h3C);
    pop_one();
    set_cfg(2'd2, 1'b0, 4'd6);
    cyc(1'b1, 1'b1, 4'h3);
    cyc(1'b0, 1'b1, 4'hF);
    chk("quad_len6", 32'(rx_data), 32'h0F);
    pop_one();

    // Overflow: five one-cycle quad frames with no consumer
    set_cfg(2'd2, 1'b0, 4'd4);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 1'b1, 4'(k));
      cyc(1'b0, 1'b0, 4'h0);
    end
    chk("ovf_count", 32'(rx_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    rx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", 32'(rx_data), 32'(k));
      tick();
    end
    rx_ready = 1'b0;
    chk("drain_empty", 32'(rx_valid), 32'd0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Restart mid-frame; restarting sample counts as bit 1
    set_cfg(2'd0, 1'b0, 4'd8);
    cyc(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b1, 1'b1, 4'hF);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 4'hF);
    chk("restart_count", 32'(rx_count), 32'd1);
    chk("restart_data", 32'(rx_data), 32'hFF);
    pop_one();

    // Reset mid-frame with two entries queued
    set_cfg(2'd2, 1'b0, 4'd8);
    cyc(1'b1, 1'b1, 4'h1);
    cyc(1'b0, 1'b1, 4'h2);
    cyc(1'b1, 1'b1, 4'h3);
    cyc(1'b0, 1'b1, 4'h4);
    cyc(1'b1, 1'b1, 4'h5);
    chk("pre_reset_count", 32'(rx_count), 32'd2);
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 4'h6);
    chk("no_phantom", 32'(rx_count), 32'd0);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      fs        = ($urandom_range(0, 5) == 0);
      smp       = ($urandom_range(0, 1) == 1);
      dq        = 4'($urandom_range(0, 15));
      rx_ready  = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      tick();
    end
    fs = 1'b0; smp = 1'b0; rx_ready = 1'b0; clear_ovf = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
